// File: rtl/mic_direction_detector_pkg.sv
// Shared definitions for the microphone direction detector: FSM states and steering polarity.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mic_direction_detector_pkg;

  // Detector FSM states; the direction controller decodes the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_WAIT_L = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // BallSignal polarity.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  // The shared skew/holdoff counter must hold both the skew range and the holdoff count.
  function automatic int unsigned cnt_width(input int unsigned skew_w, input int unsigned holdoff);
    int unsigned hw;
    hw = $clog2(holdoff + 1);
    return (hw > skew_w) ? hw : skew_w;
  endfunction

endpackage

// File: rtl/mic_edge_sync.sv
// Two-flop synchroniser for an asynchronous comparator output, followed by a rising-edge pulse.
// Latency: a pin rise is seen as a 1-cycle pulse that the consumer acts on at the 3rd clock edge.
// Backpressure: none; every synchronised rising edge produces exactly one pulse.
module mic_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/mic_direction_detector.sv
// Timestamps left/right mic pulse arrivals, votes on the leading side and flags a centred ball.
// Latency: pair result registered one cycle after the closing edge (edges lag pins by 3 cycles).
// Backpressure: none; edges outside ARMED/WAIT (including during holdoff) are dropped by design.
module mic_direction_detector
  import mic_direction_detector_pkg::*;
#(
  parameter int unsigned MAX_SKEW    = 100_000,
  parameter int unsigned CENTER_SKEW = 5_000,
  parameter int unsigned VOTE_N      = 3,
  parameter int unsigned DET_N       = 8,
  parameter int unsigned HOLDOFF     = 2_000_000,
  parameter int unsigned SKEW_W      = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Enable,
  input  logic              Mic_L,
  input  logic              Mic_R,
  output logic              BallSignal,
  output logic              Ball_Detect,
  output logic              Pair_Valid,
  output logic [SKEW_W-1:0] Skew,
  output logic              Skew_Right
);

  localparam int unsigned CNT_W  = cnt_width(SKEW_W, HOLDOFF);
  localparam int unsigned VOTE_W = $clog2(VOTE_N + 1);
  localparam int unsigned DET_W  = $clog2(DET_N + 1);

  localparam logic [CNT_W-1:0]  SKEW_LIMIT = CNT_W'(MAX_SKEW);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF - 1);
  localparam logic [SKEW_W-1:0] CENTER_LIM = SKEW_W'(CENTER_SKEW);
  localparam logic [VOTE_W-1:0] VOTE_MAX   = VOTE_W'(VOTE_N);
  localparam logic [DET_W-1:0]  DET_MAX    = DET_W'(DET_N);

  logic l_edge;
  logic r_edge;

  mic_edge_sync u_sync_l (.clk(clk), .rst_n(rst_n), .pin(Mic_L), .rise(l_edge));
  mic_edge_sync u_sync_r (.clk(clk), .rst_n(rst_n), .pin(Mic_R), .rise(r_edge));

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic              pair;
  logic [SKEW_W-1:0] pair_skew;
  logic              pair_right;

  logic              vote_side, side_n;
  logic [VOTE_W-1:0] vote_cnt, vote_n;
  logic [DET_W-1:0]  det_cnt, det_n;
  logic              centred;

  // State and shared skew/holdoff counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: pairing of edges, skew timeout and echo holdoff.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cnt_inc    = cnt + 1'b1;
    pair       = 1'b0;
    pair_skew  = '0;
    pair_right = DIR_LEFT;
    if (!Enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_ARMED;
          cnt_n   = '0;
        end
        ST_ARMED: begin
          cnt_n = '0;
          if (l_edge && r_edge) begin
            pair    = 1'b1;
            state_n = ST_HOLD;
          end else if (l_edge) begin
            state_n = ST_WAIT_R;
          end else if (r_edge) begin
            state_n = ST_WAIT_L;
          end
        end
        ST_WAIT_R: begin
          if (r_edge) begin
            pair      = 1'b1;
            pair_skew = SKEW_W'(cnt_inc);
            state_n   = ST_HOLD;
            cnt_n     = '0;
          end else if (cnt_inc >= SKEW_LIMIT) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_WAIT_L: begin
          if (l_edge) begin
            pair       = 1'b1;
            pair_skew  = SKEW_W'(cnt_inc);
            pair_right = DIR_RIGHT;
            state_n    = ST_HOLD;
            cnt_n      = '0;
          end else if (cnt_inc >= SKEW_LIMIT) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n = ST_ARMED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Vote/detect counter updates for the pair completing this cycle.
  always_comb begin
    centred = (pair_skew <= CENTER_LIM);
    side_n  = vote_side;
    vote_n  = vote_cnt;
    det_n   = det_cnt;
    if (centred) begin
      det_n  = (det_cnt == DET_MAX) ? det_cnt : det_cnt + 1'b1;
      vote_n = '0;
    end else begin
      det_n = '0;
      if (pair_right == vote_side) begin
        vote_n = (vote_cnt == VOTE_MAX) ? vote_cnt : vote_cnt + 1'b1;
      end else begin
        side_n = pair_right;
        vote_n = VOTE_W'(1);
      end
    end
  end

  // Pair result outputs, vote state and the steering/detect flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Pair_Valid  <= 1'b0;
      Skew        <= '0;
      Skew_Right  <= 1'b0;
      BallSignal  <= DIR_RIGHT;
      Ball_Detect <= 1'b0;
      vote_side   <= DIR_RIGHT;
      vote_cnt    <= '0;
      det_cnt     <= '0;
    end else begin
      Pair_Valid <= pair;
      if (!Enable) begin
        vote_cnt    <= '0;
        det_cnt     <= '0;
        Ball_Detect <= 1'b0;
      end else if (pair) begin
        Skew       <= pair_skew;
        Skew_Right <= pair_right;
        vote_side  <= side_n;
        vote_cnt   <= vote_n;
        det_cnt    <= det_n;
        if (det_n == DET_MAX) begin
          Ball_Detect <= 1'b1;
        end
        // Once the ball is located the steering direction is frozen.
        if (vote_n == VOTE_MAX && !Ball_Detect) begin
          BallSignal <= side_n;
        end
      end
    end
  end

endmodule
